// File: rtl/if_fetch_queue_if.sv
// Bus bundle between the fetch queue, the instruction memory, execute (redirects) and decode.
// With IF_PERF_CNT_EN defined it also carries the fetch/stall performance counters.
interface if_fetch_queue_if;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        misalign;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  modport master (
    output imem_pc, id_valid, id_pc, id_inst, misalign, perf_fetch_cnt, perf_stall_cnt,
    input  imem_inst, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  imem_pc, id_valid, id_pc, id_inst, misalign, perf_fetch_cnt, perf_stall_cnt,
    output imem_inst, redirect_valid, redirect_pc, id_ready
  );
`else
  modport master (
    output imem_pc, id_valid, id_pc, id_inst, misalign,
    input  imem_inst, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  imem_pc, id_valid, id_pc, id_inst, misalign,
    output imem_inst, redirect_valid, redirect_pc, id_ready
  );
`endif
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, buffers {pc, inst} pairs for decode, flushes on redirect.
// Optional performance counters are enabled with the IF_PERF_CNT_EN macro.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_queue_if.master bus
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  logic [31:0]   fetch_pc_r;
  logic [63:0]   mem_r [QDEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          misalign_r;

  logic          pop_s;
  logic          push_s;
  logic          full_s;
  logic [31:0]   fetch_pc_nxt_s;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic [PW-1:0] wr_ptr_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic          misalign_nxt_s;
  logic          id_valid_s;
  logic [31:0]   id_pc_s;
  logic [31:0]   id_inst_s;

  // Handshake qualifiers; a pop frees a slot for a push in the same cycle.
  always_comb begin
    full_s = (count_r == FULL_CNT);
    pop_s  = (count_r != {CW{1'b0}}) && bus.id_ready;
    push_s = !bus.redirect_valid && (!full_s || pop_s);
  end

  // Next-state for PC, pointers, occupancy and misalign; redirect overrides everything.
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    count_nxt_s    = count_r;
    misalign_nxt_s = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_nxt_s = {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_nxt_s   = {PW{1'b0}};
      wr_ptr_nxt_s   = {PW{1'b0}};
      count_nxt_s    = {CW{1'b0}};
      misalign_nxt_s = |bus.redirect_pc[1:0];
    end else begin
      if (push_s) begin
        fetch_pc_nxt_s = fetch_pc_r + 32'd4;
        wr_ptr_nxt_s   = wr_ptr_r + PW'(1);
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      misalign_r <= 1'b0;
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      count_r    <= count_nxt_s;
      misalign_r <= misalign_nxt_s;
    end
  end

  // Buffer storage; cleared on reset so no stale pair can ever be presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_r[i] <= 64'h0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {fetch_pc_r, bus.imem_inst};
    end
  end

  // Head entry presentation, zeroed while the buffer is empty.
  always_comb begin
    id_valid_s = (count_r != {CW{1'b0}});
    if (id_valid_s) begin
      id_pc_s   = mem_r[rd_ptr_r][63:32];
      id_inst_s = mem_r[rd_ptr_r][31:0];
    end else begin
      id_pc_s   = 32'h0;
      id_inst_s = 32'h0;
    end
  end

  assign bus.imem_pc  = fetch_pc_r;
  assign bus.id_valid = id_valid_s;
  assign bus.id_pc    = id_pc_s;
  assign bus.id_inst  = id_inst_s;
  assign bus.misalign = misalign_r;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_r;
  logic [31:0] perf_stall_r;
  logic        stall_s;

  // Fetch is blocked when the buffer is full, decode is not draining and no redirect flushes it.
  always_comb begin
    stall_s = full_s && !pop_s && !bus.redirect_valid;
  end

  // Free-running wrapping counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_r <= 32'h0;
      perf_stall_r <= 32'h0;
    end else begin
      if (push_s) begin
        perf_fetch_r <= perf_fetch_r + 32'd1;
      end
      if (stall_s) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign bus.perf_fetch_cnt = perf_fetch_r;
  assign bus.perf_stall_cnt = perf_stall_r;
`endif

endmodule
